// File: rtl/d_roteador_if.sv
// Request channel into d_roteador: one routing request (data bit + 2-bit select)
// per accepted valid/ready transfer.
interface d_roteador_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_d;
  logic [1:0] in_s;

  modport master (output in_valid, output in_d, output in_s, input in_ready);
  modport slave  (input in_valid, input in_d, input in_s, output in_ready);
endinterface

// File: rtl/d_roteador.sv
// Routing controller for the d_fluxo demux: FIFO-buffers requests and presents each
// on d/s for HOLD cycles. Define D_ROTEADOR_GUARD_EN to add a 1-cycle d=0 gap between requests.
module d_roteador #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  d_roteador_if.slave                bus,
  output logic                       d,
  output logic [1:0]                 s,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

`ifdef D_ROTEADOR_GUARD_EN
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GUARD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;
`endif

  state_t          state, next_state;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push, pop;
  logic [2:0]      head;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign bus.in_ready = (level != LVL_FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];
  assign done         = (state == S_HOLD) && (cnt == CNT_LAST);
  assign busy         = (state != S_IDLE);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == CNT_LAST) begin
`ifdef D_ROTEADOR_GUARD_EN
          next_state = S_GUARD;
`else
          if (level != '0) begin
            pop        = 1'b1;
            next_state = S_HOLD;
          end else begin
            next_state = S_IDLE;
          end
`endif
        end
      end
`ifdef D_ROTEADOR_GUARD_EN
      S_GUARD: begin
        if (level != '0) begin
          pop        = 1'b1;
          next_state = S_HOLD;
        end else begin
          next_state = S_IDLE;
        end
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Storage is not reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_s, bus.in_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state <= next_state;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // d drops to 0 whenever the next cycle is not a presentation cycle; s keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= 1'b0;
      s   <= 2'b00;
      cnt <= '0;
    end else if (pop) begin
      d   <= head[0];
      s   <= head[2:1];
      cnt <= '0;
    end else if (next_state == S_HOLD) begin
      cnt <= cnt + CW'(1);
    end else begin
      d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_d_roteador.sv
// Self-checking bench for d_roteador: scoreboard of accepted requests checked on every done pulse,
// plus per-scenario timing checks.
module tb_d_roteador;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef D_ROTEADOR_GUARD_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          d;
  logic [1:0]    s;
  logic          busy;
  logic          done;
  logic [LW-1:0] level;

  d_roteador_if bus ();

  d_roteador #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .d     (d),
    .s     (s),
    .busy  (busy),
    .done  (done),
    .level (level)
  );

  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [2:0] exp_q[$];
  int         done_times[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse must present the oldest outstanding request.
  initial begin
    logic [2:0] exp_item;
    forever begin
      @(posedge clk);
      cycle++;
      #2;
      if (rst_n === 1'b1 && done === 1'b1) begin
        done_times.push_back(cycle);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_order: done with s=%0d d=%0b, required no output", s, d);
        end else begin
          exp_item = exp_q.pop_front();
          if ({s, d} !== exp_item) begin
            errors++;
            $display("[TB] FAIL sb_order: got s=%0d d=%0b, required s=%0d d=%0b",
                     s, d, exp_item[2:1], exp_item[0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high on return so callers can chain requests back-to-back.
  task automatic offer(input logic dd, input logic [1:0] ss, output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_d     = dd;
    bus.in_s     = ss;
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL offer_timeout: in_ready=%0b, required 1 within 200 cycles", bus.in_ready);
    end else begin
      exp_q.push_back({ss, dd});
    end
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(busy === 1'b0 && level === '0) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (!(busy === 1'b0 && level === '0)) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%0b level=%0d, required 0/0", busy, level);
    end
    tick();
  endtask

  task automatic test_reset();
    int w;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_d = 1'b0;
    bus.in_s = 2'b00;
    tick();
    tick();
    checks += 6;
    if (d !== 1'b0)             begin errors++; $display("[TB] FAIL rst_d: got %0b, required 0", d); end
    if (s !== 2'b00)            begin errors++; $display("[TB] FAIL rst_s: got %0d, required 0", s); end
    if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL rst_busy: got %0b, required 0", busy); end
    if (done !== 1'b0)          begin errors++; $display("[TB] FAIL rst_done: got %0b, required 0", done); end
    if (level !== '0)           begin errors++; $display("[TB] FAIL rst_level: got %0d, required 0", level); end
    if (bus.in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL rst_ready: got %0b, required 1", bus.in_ready); end
    rst_n = 1'b1;
    tick();
    offer(1'b1, 2'd3, w);
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (d !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre: got d=%0b busy=%0b, required 1/1", d, busy);
    end
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks += 4;
    if (d !== 1'b0)    begin errors++; $display("[TB] FAIL async_d: got %0b, required 0", d); end
    if (s !== 2'b00)   begin errors++; $display("[TB] FAIL async_s: got %0d, required 0", s); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %0b, required 0", busy); end
    if (level !== '0)  begin errors++; $display("[TB] FAIL async_level: got %0d, required 0", level); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_request();
    int w;
    offer(1'b1, 2'd2, w);
    bus.in_valid = 1'b0;
    checks++;
    if (level !== LW'(1) || d !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_push: got level=%0d d=%0b busy=%0b, required 1/0/0", level, d, busy);
    end
    tick();
    for (int k = 0; k < HOLD; k++) begin
      checks++;
      if (d !== 1'b1 || s !== 2'd2 || busy !== 1'b1 || done !== (k == HOLD - 1)) begin
        errors++;
        $display("[TB] FAIL single_hold%0d: got d=%0b s=%0d busy=%0b done=%0b, required 1/2/1/%0b",
                 k, d, s, busy, done, (k == HOLD - 1));
      end
      tick();
    end
    checks++;
    if (d !== 1'b0 || s !== 2'd2 || done !== 1'b0 || busy !== (GAP == 1)) begin
      errors++;
      $display("[TB] FAIL single_after: got d=%0b s=%0d busy=%0b done=%0b, required 0/2/%0b/0",
               d, s, busy, done, (GAP == 1));
    end
    tick();
    checks++;
    if (busy !== 1'b0 || d !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got busy=%0b d=%0b, required 0/0", busy, d);
    end
  endtask

  task automatic test_sweep();
    int w;
    done_times.delete();
    offer(1'b1, 2'd0, w);
    offer(1'b0, 2'd1, w);
    offer(1'b1, 2'd2, w);
    offer(1'b1, 2'd3, w);
    bus.in_valid = 1'b0;
    wait_idle();
    checks++;
    if (done_times.size() != 4) begin
      errors++;
      $display("[TB] FAIL sweep_done_count: got %0d, required 4", done_times.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (done_times[i] - done_times[i-1] != HOLD + GAP) begin
          errors++;
          $display("[TB] FAIL sweep_spacing%0d: got %0d, required %0d",
                   i, done_times[i] - done_times[i-1], HOLD + GAP);
        end
      end
    end
  endtask

  task automatic test_full_fifo();
    int w;
    offer(1'b1, 2'd1, w);
    offer(1'b0, 2'd2, w);
    checks++;
    if (level !== LW'(1) || d !== 1'b1 || s !== 2'd1) begin
      errors++;
      $display("[TB] FAIL full_push_pop: got level=%0d d=%0b s=%0d, required 1/1/1", level, d, s);
    end
    offer(1'b1, 2'd3, w);
    offer(1'b1, 2'd0, w);
    offer(1'b0, 2'd3, w);
    checks++;
    if (level !== LW'(DEPTH) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_level: got level=%0d in_ready=%0b, required %0d/0", level, bus.in_ready, DEPTH);
    end
    offer(1'b1, 2'd2, w);
    checks += 2;
    if (w < 1) begin
      errors++;
      $display("[TB] FAIL full_blocked: got wait %0d cycles, required >= 1", w);
    end
    if (level !== LW'(DEPTH)) begin
      errors++;
      $display("[TB] FAIL full_refill: got level=%0d, required %0d", level, DEPTH);
    end
    bus.in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_pointer_wrap();
    int w;
    for (int i = 0; i < 10; i++) begin
      offer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), w);
      checks++;
      if (level > LW'(DEPTH)) begin
        errors++;
        $display("[TB] FAIL wrap_level%0d: got %0d, required <= %0d", i, level, DEPTH);
      end
    end
    bus.in_valid = 1'b0;
    wait_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wrap_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_in_hold();
    int w;
    int stale = 0;
    offer(1'b1, 2'd1, w);
    offer(1'b1, 2'd2, w);
    offer(1'b0, 2'd3, w);
    bus.in_valid = 1'b0;
    checks++;
    if (level !== LW'(2) || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rh_pre: got level=%0d busy=%0b, required 2/1", level, busy);
    end
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (level !== '0 || busy !== 1'b0 || d !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rh_after: got level=%0d busy=%0b d=%0b ready=%0b, required 0/0/0/1",
               level, busy, d, bus.in_ready);
    end
    for (int k = 0; k < 3 * HOLD; k++) begin
      if (busy !== 1'b0 || done !== 1'b0 || d !== 1'b0) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("[TB] FAIL rh_stale: got %0d active cycles, required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_sweep();
    test_full_fifo();
    test_pointer_wrap();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
